// File: rtl/mp_fifo_ptr_input.sv
// In-order FIFO whose entries are allocated in order, filled by pointer in any order,
// and drained in order; draining stalls at the oldest entry that has not been written.
module mp_fifo_ptr_input #(
    parameter int PAYLOAD_WIDTH  = 64,
    parameter int ENQUEUE_WIDTH  = 2,
    parameter int WB_WIDTH       = 2,
    parameter int DEQUEUE_WIDTH  = 2,
    parameter int DEPTH          = 8,
    parameter int MUST_TAKEN_ALL = 1,
    localparam int PTRW          = $clog2(DEPTH),
    localparam int CNTW          = $clog2(DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic [ENQUEUE_WIDTH-1:0]               alloc_vld_i,
    output logic [ENQUEUE_WIDTH-1:0]               alloc_rdy_o,
    output logic [ENQUEUE_WIDTH*PTRW-1:0]          alloc_ptr_o,
    input  logic [WB_WIDTH-1:0]                    wb_vld_i,
    input  logic [WB_WIDTH*PTRW-1:0]               wb_ptr_i,
    input  logic [WB_WIDTH*PAYLOAD_WIDTH-1:0]      wb_payload_i,
    output logic [DEQUEUE_WIDTH-1:0]               dequeue_vld_o,
    output logic [DEQUEUE_WIDTH*PAYLOAD_WIDTH-1:0] dequeue_payload_o,
    input  logic [DEQUEUE_WIDTH-1:0]               dequeue_rdy_i
);

    logic [PTRW-1:0]          head_q, tail_q, head_nxt, tail_nxt;
    logic [CNTW-1:0]          avail_q, avail_nxt, used_cnt;
    logic [DEPTH-1:0]         alloc_q, written_q, alloc_nxt, written_nxt;
    logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
    logic [ENQUEUE_WIDTH-1:0] alloc_fire;
    logic [DEQUEUE_WIDTH-1:0] deq_fire;
    logic [WB_WIDTH-1:0]      wb_ok;
    logic                     clear;
    int                       n_alloc, n_deq;

    function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTRW'(s);
    endfunction

    assign clear    = rst | flush_i;
    assign used_cnt = CNTW'(DEPTH) - avail_q;

    always_comb begin
        alloc_rdy_o = '0;
        alloc_ptr_o = '0;
        for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
            if (MUST_TAKEN_ALL != 0) alloc_rdy_o[i] = (int'(avail_q) >= ENQUEUE_WIDTH);
            else                     alloc_rdy_o[i] = (int'(avail_q) > i);
            alloc_ptr_o[i*PTRW +: PTRW] = ptr_add(tail_q, i);
        end
    end

    // Valid is a prefix: entry k is offered only if every older entry is offered too.
    always_comb begin
        logic prev;
        dequeue_vld_o     = '0;
        dequeue_payload_o = '0;
        prev              = 1'b1;
        for (int k = 0; k < DEQUEUE_WIDTH; k++) begin
            dequeue_vld_o[k] = prev && (int'(used_cnt) > k) && written_q[ptr_add(head_q, k)];
            prev             = dequeue_vld_o[k];
            dequeue_payload_o[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = payload_q[ptr_add(head_q, k)];
        end
    end

    assign alloc_fire = alloc_vld_i & alloc_rdy_o;
    assign deq_fire   = dequeue_vld_o & dequeue_rdy_i;

    always_comb begin
        wb_ok = '0;
        for (int j = 0; j < WB_WIDTH; j++) begin
            wb_ok[j] = wb_vld_i[j] && !clear && (int'(wb_ptr_i[j*PTRW +: PTRW]) < DEPTH)
                       && alloc_q[wb_ptr_i[j*PTRW +: PTRW]];
        end
    end

    always_comb begin
        alloc_nxt   = alloc_q;
        written_nxt = written_q;
        n_alloc     = 0;
        n_deq       = 0;
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (wb_ok[j]) written_nxt[wb_ptr_i[j*PTRW +: PTRW]] = 1'b1;
        end
        for (int k = 0; k < DEQUEUE_WIDTH; k++) begin
            if (deq_fire[k]) begin
                alloc_nxt[ptr_add(head_q, k)]   = 1'b0;
                written_nxt[ptr_add(head_q, k)] = 1'b0;
                n_deq++;
            end
        end
        for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
            if (alloc_fire[i]) begin
                alloc_nxt[ptr_add(tail_q, i)]   = 1'b1;
                written_nxt[ptr_add(tail_q, i)] = 1'b0;
                n_alloc++;
            end
        end
        head_nxt  = ptr_add(head_q, n_deq);
        tail_nxt  = ptr_add(tail_q, n_alloc);
        avail_nxt = CNTW'(int'(avail_q) - n_alloc + n_deq);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            head_q    <= '0;
            tail_q    <= '0;
            avail_q   <= CNTW'(DEPTH);
            alloc_q   <= '0;
            written_q <= '0;
        end else begin
            head_q    <= head_nxt;
            tail_q    <= tail_nxt;
            avail_q   <= avail_nxt;
            alloc_q   <= alloc_nxt;
            written_q <= written_nxt;
        end
    end

    // Payload storage carries no reset; entries are qualified by written_q.
    always_ff @(posedge clk) begin
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (wb_ok[j])
                payload_q[wb_ptr_i[j*PTRW +: PTRW]] <= wb_payload_i[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        end
    end

    always @(posedge clk) begin
        if (!clear) begin
            for (int j = 0; j < WB_WIDTH; j++) begin
                if (wb_vld_i[j]) begin
                    assert ((int'(wb_ptr_i[j*PTRW +: PTRW]) < DEPTH)
                            && alloc_q[wb_ptr_i[j*PTRW +: PTRW]]
                            && !written_q[wb_ptr_i[j*PTRW +: PTRW]]);
                end
                for (int l = j + 1; l < WB_WIDTH; l++) begin
                    if (wb_vld_i[j] && wb_vld_i[l])
                        assert (wb_ptr_i[j*PTRW +: PTRW] != wb_ptr_i[l*PTRW +: PTRW]);
                end
            end
        end
    end

endmodule
